// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch requester, the data requester, the arbiter and the single-port RAM.
// Handshake: a requester raises x_req with its address/data stable and keeps them until
// the one-cycle x_ack pulse; it may lower x_req, or present a new request, the cycle after.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_ack;
  logic [DW-1:0] f_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  // Environment side: both requesters plus the RAM read port.
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_q,
    input  f_ack, f_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_rden, mem_wren
  );

  // Arbiter side.
  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_q,
    output f_ack, f_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_rden, mem_wren
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port synchronous RAM: data has priority, fetch wins after
// MAX_WAIT denied cycles. Optional ARB_STATS_EN adds fetch_stall_cnt and data_access_cnt.
module mem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 3
) (
  input  logic       clock,
  input  logic       reset,
  mem_port_arbiter_if.slave bus,
  output logic       busy,
  output logic [1:0] dbg_state_o,
  output logic [3:0] dbg_wait_cnt_o
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] fetch_stall_cnt,
  output logic [15:0] data_access_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_F = 2'd1,
    RESP_D = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          f_ack_q, d_ack_q, busy_q, d_store_q;
  logic [DW-1:0] f_rdata_q, d_rdata_q;
  logic          f_elig, d_elig, grant_f, grant_d;
  logic [AW-1:0] mem_addr_c;
  logic [DW-1:0] mem_wdata_c;
  logic          mem_rden_c, mem_wren_c;

  always_comb begin
    f_elig      = bus.f_req && (state_q != RESP_F);
    d_elig      = bus.d_req && (state_q != RESP_D);
    grant_f     = f_elig && (!d_elig || (wait_cnt_q >= 4'(MAX_WAIT)));
    grant_d     = d_elig && !grant_f;
    // Nothing is issued while reset is held so the RAM sees no stray write.
    if (reset) begin
      grant_f = 1'b0;
      grant_d = 1'b0;
    end
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    mem_rden_c  = 1'b0;
    mem_wren_c  = 1'b0;
    state_d     = IDLE;
    if (grant_f) begin
      mem_addr_c = bus.f_addr;
      mem_rden_c = 1'b1;
      state_d    = RESP_F;
    end else if (grant_d) begin
      mem_addr_c = bus.d_addr;
      state_d    = RESP_D;
      if (bus.d_we) begin
        mem_wdata_c = bus.d_wdata;
        mem_wren_c  = 1'b1;
      end else begin
        mem_rden_c = 1'b1;
      end
    end
    wait_cnt_d = wait_cnt_q;
    if (!bus.f_req || grant_f) wait_cnt_d = 4'd0;
    else if (f_elig && (wait_cnt_q != 4'hF)) wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      f_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
      d_store_q  <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      f_ack_q    <= grant_f;
      d_ack_q    <= grant_d;
      busy_q     <= grant_f || grant_d;
      d_store_q  <= grant_d && bus.d_we;
      if (f_ack_q) f_rdata_q <= bus.mem_q;
      if (d_ack_q && !d_store_q) d_rdata_q <= bus.mem_q;
    end
  end

  // RAM data arrives during the RESP cycle, so read data bypasses the hold register there.
  assign bus.f_rdata   = f_ack_q ? bus.mem_q : f_rdata_q;
  assign bus.d_rdata   = (d_ack_q && !d_store_q) ? bus.mem_q : d_rdata_q;
  assign bus.f_ack     = f_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_rden  = mem_rden_c;
  assign bus.mem_wren  = mem_wren_c;
  assign busy          = busy_q;
  assign dbg_state_o   = state_q;
  assign dbg_wait_cnt_o = wait_cnt_q;

`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt_q, access_cnt_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= 16'd0;
      access_cnt_q <= 16'd0;
    end else begin
      if (bus.f_req && !grant_f) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (d_ack_q) access_cnt_q <= access_cnt_q + 16'd1;
    end
  end
  assign fetch_stall_cnt = stall_cnt_q;
  assign data_access_cnt = access_cnt_q;
`endif

  a_f_req_held: assert property (@(posedge clock) disable iff (reset)
    (bus.f_req && !bus.f_ack) |=> bus.f_req);
  a_d_req_held: assert property (@(posedge clock) disable iff (reset)
    (bus.d_req && !bus.d_ack) |=> bus.d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (MAX_WAIT=3 and MAX_WAIT=1), each with a RAM model.
module tb_mem_port_arbiter;
  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  logic       busy0, busy1;
  logic [1:0] st0, st1;
  logic [3:0] wc0, wc1;
`ifdef ARB_STATS_EN
  logic [15:0] fsc0, dac0, fsc1, dac1;
`endif

  mem_port_arbiter_if #(.AW(8), .DW(8)) b0 ();
  mem_port_arbiter_if #(.AW(8), .DW(8)) b1 ();

  mem_port_arbiter #(.AW(8), .DW(8), .MAX_WAIT(3)) dut (
    .clock(clock), .reset(reset), .bus(b0), .busy(busy0),
    .dbg_state_o(st0), .dbg_wait_cnt_o(wc0)
`ifdef ARB_STATS_EN
    , .fetch_stall_cnt(fsc0), .data_access_cnt(dac0)
`endif
  );

  mem_port_arbiter #(.AW(8), .DW(8), .MAX_WAIT(1)) dut1 (
    .clock(clock), .reset(reset), .bus(b1), .busy(busy1),
    .dbg_state_o(st1), .dbg_wait_cnt_o(wc1)
`ifdef ARB_STATS_EN
    , .fetch_stall_cnt(fsc1), .data_access_cnt(dac1)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // single-port synchronous RAM models, read data one cycle after the address edge
  always @(posedge clock) begin
    if (b0.mem_wren) mem0[b0.mem_addr] <= b0.mem_wdata;
    if (b0.mem_rden) b0.mem_q <= mem0[b0.mem_addr];
    if (b1.mem_wren) mem1[b1.mem_addr] <= b1.mem_wdata;
    if (b1.mem_rden) b1.mem_q <= mem1[b1.mem_addr];
  end

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clock);
    checks++; if (b0.f_ack !== 1'b0) begin errors++; $display("FAIL reset_f_ack got %b exp 0", b0.f_ack); end
    checks++; if (b0.d_ack !== 1'b0) begin errors++; $display("FAIL reset_d_ack got %b exp 0", b0.d_ack); end
    checks++; if ({b0.mem_rden, b0.mem_wren} !== 2'b00) begin errors++; $display("FAIL reset_mem_en got %b exp 00", {b0.mem_rden, b0.mem_wren}); end
    checks++; if ({b0.mem_addr, b0.mem_wdata} !== 16'h0000) begin errors++; $display("FAIL reset_mem_bus got %h exp 0000", {b0.mem_addr, b0.mem_wdata}); end
    checks++; if ({b0.f_rdata, b0.d_rdata} !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h exp 0000", {b0.f_rdata, b0.d_rdata}); end
    checks++; if ({busy0, st0, wc0} !== 7'd0) begin errors++; $display("FAIL reset_busy_state_wait got %b exp 0", {busy0, st0, wc0}); end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_fetch_only;
    b0.f_req = 1'b1; b0.f_addr = 8'h05;
    @(negedge clock);
    checks++; if ({b0.mem_rden, b0.mem_wren, b0.mem_addr} !== {2'b10, 8'h05}) begin errors++; $display("FAIL fetch_issue got %b/%h exp 10/05", {b0.mem_rden, b0.mem_wren}, b0.mem_addr); end
    next_cycle;
    @(negedge clock);
    checks++; if ({b0.f_ack, busy0, b0.f_rdata} !== {2'b11, 8'hA3}) begin errors++; $display("FAIL fetch_ack got %b%b/%h exp 11/a3", b0.f_ack, busy0, b0.f_rdata); end
    checks++; if (b0.mem_rden !== 1'b0) begin errors++; $display("FAIL fetch_masked got %b exp 0", b0.mem_rden); end
    next_cycle;
    @(negedge clock);
    checks++; if ({b0.mem_rden, b0.f_ack} !== 2'b10) begin errors++; $display("FAIL fetch_reissue got %b exp 10", {b0.mem_rden, b0.f_ack}); end
    next_cycle;
    @(negedge clock);
    checks++; if (b0.f_ack !== 1'b1) begin errors++; $display("FAIL fetch_ack2 got %b exp 1", b0.f_ack); end
    next_cycle;
    b0.f_req = 1'b0;
    @(negedge clock);
    checks++; if ({b0.f_ack, busy0, b0.f_rdata} !== {2'b00, 8'hA3}) begin errors++; $display("FAIL fetch_hold got %b%b/%h exp 00/a3", b0.f_ack, busy0, b0.f_rdata); end
  endtask

  task automatic test_store_load;
    next_cycle;
    b0.d_req = 1'b1; b0.d_we = 1'b1; b0.d_addr = 8'h10; b0.d_wdata = 8'h5C;
    @(negedge clock);
    checks++; if ({b0.mem_wren, b0.mem_rden, b0.mem_addr, b0.mem_wdata} !== {2'b10, 8'h10, 8'h5C}) begin errors++; $display("FAIL store_issue got %b/%h/%h exp 10/10/5c", {b0.mem_wren, b0.mem_rden}, b0.mem_addr, b0.mem_wdata); end
    next_cycle;
    @(negedge clock);
    checks++; if ({b0.d_ack, b0.mem_wren, b0.d_rdata} !== {2'b10, 8'h00}) begin errors++; $display("FAIL store_ack got %b/%h exp 10/00", {b0.d_ack, b0.mem_wren}, b0.d_rdata); end
    next_cycle;
    b0.d_we = 1'b0;
    @(negedge clock);
    checks++; if ({b0.mem_rden, b0.mem_wren, b0.mem_addr} !== {2'b10, 8'h10}) begin errors++; $display("FAIL load_issue got %b/%h exp 10/10", {b0.mem_rden, b0.mem_wren}, b0.mem_addr); end
    next_cycle;
    @(negedge clock);
    checks++; if ({b0.d_ack, b0.d_rdata} !== {1'b1, 8'h5C}) begin errors++; $display("FAIL load_ack got %b/%h exp 1/5c", b0.d_ack, b0.d_rdata); end
    next_cycle;
    b0.d_req = 1'b0;
  endtask

  task automatic test_contention;
    logic [7:0] exp_a;
    int run;
    int max_run;
    run = 0; max_run = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 8'h20 : 8'h05);
    next_cycle;
    b0.f_req = 1'b1; b0.f_addr = 8'h05;
    b0.d_req = 1'b1; b0.d_we = 1'b0; b0.d_addr = 8'h20;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      exp_a = exp_q.pop_front();
      checks++; if (b0.mem_addr !== exp_a) begin errors++; $display("FAIL contention_grant[%0d] got %h exp %h", i, b0.mem_addr, exp_a); end
      if (i % 2 == 1) begin
        checks++; if ({b0.d_ack, b0.d_rdata} !== {1'b1, 8'h3E}) begin errors++; $display("FAIL contention_d_ack[%0d] got %b/%h exp 1/3e", i, b0.d_ack, b0.d_rdata); end
      end else if (i > 0) begin
        checks++; if ({b0.f_ack, b0.f_rdata} !== {1'b1, 8'hA3}) begin errors++; $display("FAIL contention_f_ack[%0d] got %b/%h exp 1/a3", i, b0.f_ack, b0.f_rdata); end
      end
      if (i == 1) begin
        checks++; if (wc0 !== 4'd1) begin errors++; $display("FAIL contention_wait got %0d exp 1", wc0); end
      end
      if (b0.mem_addr !== 8'h05) run++; else run = 0;
      if (run > max_run) max_run = run;
      next_cycle;
    end
    checks++; if (max_run > 4) begin errors++; $display("FAIL contention_starve got %0d denied exp <=4", max_run); end
    b0.d_req = 1'b0;
    @(negedge clock);
    checks++; if ({b0.f_ack, b0.mem_rden} !== 2'b10) begin errors++; $display("FAIL contention_tail got %b exp 10", {b0.f_ack, b0.mem_rden}); end
    next_cycle;
    b0.f_req = 1'b0;
  endtask

  task automatic test_starvation_guard;
    b1.f_req = 1'b1; b1.f_addr = 8'h07;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 8'h30;
    @(negedge clock);
    checks++; if ({b1.mem_addr, wc1} !== {8'h30, 4'd0}) begin errors++; $display("FAIL guard_first got %h/%0d exp 30/0", b1.mem_addr, wc1); end
    next_cycle;
    @(negedge clock);
    checks++; if ({b1.mem_rden, b1.mem_addr, wc1} !== {1'b1, 8'h07, 4'd1}) begin errors++; $display("FAIL guard_fetch got %b/%h/%0d exp 1/07/1", b1.mem_rden, b1.mem_addr, wc1); end
    next_cycle;
    b1.d_req = 1'b0;
    @(negedge clock);
    checks++; if ({b1.f_ack, b1.f_rdata, wc1} !== {1'b1, 8'h9D, 4'd0}) begin errors++; $display("FAIL guard_ack got %b/%h/%0d exp 1/9d/0", b1.f_ack, b1.f_rdata, wc1); end
    next_cycle;
    b1.f_req = 1'b0;
  endtask

  task automatic test_reset_mid_access;
    next_cycle;
    b0.d_req = 1'b1; b0.d_we = 1'b0; b0.d_addr = 8'h10;
    next_cycle;
    reset = 1'b1; b0.d_req = 1'b0;
    #1;
    checks++; if ({b0.d_ack, busy0, st0, b0.mem_rden, b0.mem_wren} !== 6'd0) begin errors++; $display("FAIL midreset_ctrl got %b exp 0", {b0.d_ack, busy0, st0, b0.mem_rden, b0.mem_wren}); end
    checks++; if ({b0.d_rdata, b0.f_rdata, b0.mem_addr} !== 24'd0) begin errors++; $display("FAIL midreset_data got %h exp 0", {b0.d_rdata, b0.f_rdata, b0.mem_addr}); end
    next_cycle;
    reset = 1'b0;
    next_cycle;
    b0.f_req = 1'b1; b0.f_addr = 8'h00;
    @(negedge clock);
    checks++; if ({b0.mem_rden, b0.mem_addr} !== {1'b1, 8'h00}) begin errors++; $display("FAIL postreset_issue got %b/%h exp 1/00", b0.mem_rden, b0.mem_addr); end
    next_cycle;
    @(negedge clock);
    checks++; if ({b0.f_ack, b0.f_rdata} !== {1'b1, 8'h77}) begin errors++; $display("FAIL postreset_ack got %b/%h exp 1/77", b0.f_ack, b0.f_rdata); end
    next_cycle;
    b0.f_req = 1'b0;
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats;
    int exp_stall;
    int exp_acc;
    exp_stall = 0; exp_acc = 0;
    reset = 1'b1;
    next_cycle;
    reset = 1'b0;
    b0.f_req = 1'b1; b0.f_addr = 8'h05;
    b0.d_req = 1'b1; b0.d_we = 1'b0; b0.d_addr = 8'h20;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) exp_stall++;
      else exp_acc++;
      next_cycle;
    end
    b0.d_req = 1'b0;
    @(negedge clock);
    checks++; if (fsc0 !== 16'(exp_stall)) begin errors++; $display("FAIL stats_stall got %0d exp %0d", fsc0, exp_stall); end
    checks++; if (dac0 !== 16'(exp_acc)) begin errors++; $display("FAIL stats_access got %0d exp %0d", dac0, exp_acc); end
    next_cycle;
    b0.f_req = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem0[8'h05] = 8'hA3;
    mem0[8'h20] = 8'h3E;
    mem0[8'h00] = 8'h77;
    mem1[8'h07] = 8'h9D;
    mem1[8'h30] = 8'h11;
    b0.f_req = 1'b0; b0.f_addr = '0; b0.d_req = 1'b0; b0.d_we = 1'b0; b0.d_addr = '0; b0.d_wdata = '0;
    b1.f_req = 1'b0; b1.f_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    b0.mem_q = '0; b1.mem_q = '0;
    reset = 1'b1;
    @(posedge clock); #1;
    test_reset;
    test_fetch_only;
    test_store_load;
    test_contention;
    test_starvation_guard;
    test_reset_mid_access;
`ifdef ARB_STATS_EN
    test_stats;
`endif
    next_cycle;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish before 100000");
    $fatal(1);
  end
endmodule
